// File: rtl/stack_arbiter_if.sv
// Bundles the two requester streams and the downstream queue enqueue port.
// Pure wiring: no state, no latency.
// Backpressure runs from q_rdy_i back to the granted requester's rdy.
interface stack_arbiter_if;
    // requester 0
    logic         s0_valid_i;
    logic         s0_rdy_o;
    logic [127:0] s0_data_i;
    logic         s0_last_i;
    // requester 1
    logic         s1_valid_i;
    logic         s1_rdy_o;
    logic [127:0] s1_data_i;
    logic         s1_last_i;
    // downstream queue enqueue side
    logic         q_rdy_i;
    logic         q_valid_o;
    logic [127:0] q_data_o;
    logic         q_src_o;
    // status
    logic         busy_o;

    // Arbiter side: consumes requester beats, produces queue enqueues.
    modport slave (
        input  s0_valid_i, s0_data_i, s0_last_i,
        input  s1_valid_i, s1_data_i, s1_last_i,
        input  q_rdy_i,
        output s0_rdy_o, s1_rdy_o,
        output q_valid_o, q_data_o, q_src_o, busy_o
    );

    // Environment side: drives requesters and the queue ready.
    modport master (
        output s0_valid_i, s0_data_i, s0_last_i,
        output s1_valid_i, s1_data_i, s1_last_i,
        output q_rdy_i,
        input  s0_rdy_o, s1_rdy_o,
        input  q_valid_o, q_data_o, q_src_o, busy_o
    );
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester round-robin packet arbiter feeding one 128-bit queue, bursts capped at MAX_BURST beats.
// Latency: 1 cycle to arbitrate out of IDLE; beats pass through combinationally while granted.
// Backpressure: q_rdy_i is routed to the granted requester's rdy; the other requester sees rdy=0.
module stack_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    stack_arbiter_if.slave  bus
);

    // Counter holds 0..MAX_BURST-1; keep at least one bit so MAX_BURST=1 still elaborates.
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             cur_valid;
    logic             cur_last;
    logic             beat;
    logic             burst_end;
    logic             release_grant;

    // Qualify a beat of the currently granted requester and decide whether it ends the grant.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        case (state_q)
            GRANT0: begin
                cur_valid = bus.s0_valid_i;
                cur_last  = bus.s0_last_i;
            end
            GRANT1: begin
                cur_valid = bus.s1_valid_i;
                cur_last  = bus.s1_last_i;
            end
            default: begin
                cur_valid = 1'b0;
                cur_last  = 1'b0;
            end
        endcase
        // A beat only happens when the queue takes it; stalls leave everything untouched.
        beat          = cur_valid & bus.q_rdy_i;
        burst_end     = (beat_cnt_q == CNT_MAX);
        release_grant = beat & (cur_last | burst_end);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: on release prefer the other requester so contention never leaves a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.s0_valid_i && bus.s1_valid_i) begin
                    state_d = rr_ptr_q ? GRANT1 : GRANT0;
                end else if (bus.s0_valid_i) begin
                    state_d = GRANT0;
                end else if (bus.s1_valid_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (release_grant) begin
                    if (bus.s1_valid_i) begin
                        state_d = GRANT1;
                    end else if (bus.s0_valid_i) begin
                        state_d = GRANT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GRANT1: begin
                if (release_grant) begin
                    if (bus.s0_valid_i) begin
                        state_d = GRANT0;
                    end else if (bus.s1_valid_i) begin
                        state_d = GRANT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: IDLE drives everything low, a grant is a straight combinational pass-through.
    always_comb begin
        bus.s0_rdy_o  = 1'b0;
        bus.s1_rdy_o  = 1'b0;
        bus.q_valid_o = 1'b0;
        bus.q_data_o  = '0;
        bus.q_src_o   = 1'b0;
        bus.busy_o    = 1'b0;
        case (state_q)
            GRANT0: begin
                bus.q_valid_o = bus.s0_valid_i;
                bus.q_data_o  = bus.s0_data_i;
                bus.s0_rdy_o  = bus.q_rdy_i;
                bus.q_src_o   = 1'b0;
                bus.busy_o    = 1'b1;
            end
            GRANT1: begin
                bus.q_valid_o = bus.s1_valid_i;
                bus.q_data_o  = bus.s1_data_i;
                bus.s1_rdy_o  = bus.q_rdy_i;
                bus.q_src_o   = 1'b1;
                bus.busy_o    = 1'b1;
            end
            default: begin
                bus.s0_rdy_o  = 1'b0;
                bus.s1_rdy_o  = 1'b0;
            end
        endcase
    end

    // Burst counter and round-robin pointer: both move only on accepted beats.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (release_grant) begin
            beat_cnt_d = '0;
            // Point at whichever requester did not just finish.
            rr_ptr_d   = (state_q == GRANT0);
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    // Burst counter and round-robin pointer registers; requester 0 wins first after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: per-cycle vector tables plus hand sequences for reset and MAX_BURST=1.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Expected values are written by hand in each table row.
module tb_stack_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    stack_arbiter_if bus ();
    stack_arbiter_if bus1 ();

    stack_arbiter #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    stack_arbiter #(.MAX_BURST(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    typedef struct {
        logic        s0v;
        logic        s0l;
        logic [15:0] s0d;
        logic        s1v;
        logic        s1l;
        logic [15:0] s1d;
        logic        qr;
        logic        e_vld;
        logic        e_src;
        logic        e_s0r;
        logic        e_s1r;
        logic        e_busy;
        logic [1:0]  e_sel;   // 0: data 0, 1: s0 payload, 2: s1 payload
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [127:0] pay(input logic [15:0] d);
        return {8{d}};
    endfunction

    function automatic vec_t V(input logic s0v, s0l, input logic [15:0] s0d,
                               input logic s1v, s1l, input logic [15:0] s1d,
                               input logic qr, ev, es, e0r, e1r, eb,
                               input logic [1:0] esel);
        vec_t v;
        v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
        v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
        v.qr = qr; v.e_vld = ev; v.e_src = es; v.e_s0r = e0r; v.e_s1r = e1r;
        v.e_busy = eb; v.e_sel = esel;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic zero_inputs();
        bus.s0_valid_i = 0; bus.s0_last_i = 0; bus.s0_data_i = '0;
        bus.s1_valid_i = 0; bus.s1_last_i = 0; bus.s1_data_i = '0;
        bus.q_rdy_i = 0;
        bus1.s0_valid_i = 0; bus1.s0_last_i = 0; bus1.s0_data_i = '0;
        bus1.s1_valid_i = 0; bus1.s1_last_i = 0; bus1.s1_data_i = '0;
        bus1.q_rdy_i = 0;
    endtask

    task automatic drive(input vec_t v);
        bus.s0_valid_i = v.s0v; bus.s0_last_i = v.s0l; bus.s0_data_i = pay(v.s0d);
        bus.s1_valid_i = v.s1v; bus.s1_last_i = v.s1l; bus.s1_data_i = pay(v.s1d);
        bus.q_rdy_i    = v.qr;
    endtask

    task automatic check_row(input vec_t v, input string nm, input int idx);
        logic [127:0] ed;
        ed = (v.e_sel == 2'd1) ? pay(v.s0d) : (v.e_sel == 2'd2) ? pay(v.s1d) : '0;
        chk($sformatf("%s r%0d q_valid", nm, idx), bus.q_valid_o, v.e_vld);
        chk($sformatf("%s r%0d q_src",   nm, idx), bus.q_src_o,   v.e_src);
        chk($sformatf("%s r%0d s0_rdy",  nm, idx), bus.s0_rdy_o,  v.e_s0r);
        chk($sformatf("%s r%0d s1_rdy",  nm, idx), bus.s1_rdy_o,  v.e_s1r);
        chk($sformatf("%s r%0d busy",    nm, idx), bus.busy_o,    v.e_busy);
        chk($sformatf("%s r%0d q_data",  nm, idx), bus.q_data_o,  ed);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_row(tbl[i], nm, i);
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " q_valid"}, bus.q_valid_o, 1'b0);
        chk({nm, " q_src"},   bus.q_src_o,   1'b0);
        chk({nm, " s0_rdy"},  bus.s0_rdy_o,  1'b0);
        chk({nm, " s1_rdy"},  bus.s1_rdy_o,  1'b0);
        chk({nm, " busy"},    bus.busy_o,    1'b0);
        chk({nm, " q_data"},  bus.q_data_o,  128'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        zero_inputs();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        zero_inputs();
        @(posedge clk);
        #1;
        // Reset state with requests asserted: outputs must stay low.
        bus.s0_valid_i = 1; bus.s1_valid_i = 1; bus.q_rdy_i = 1;
        bus.s0_data_i = pay(16'hdead);
        @(negedge clk);
        check_all_zero("reset");

        // Alternation with single-beat packets under contention.
        do_reset();
        tbl.push_back(V(1,1,16'h0101, 1,1,16'h0201, 1, 0,0,0,0,0, 0));
        tbl.push_back(V(1,1,16'h0102, 1,1,16'h0202, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,1,16'h0103, 1,1,16'h0203, 1, 1,1,0,1,1, 2));
        tbl.push_back(V(1,1,16'h0104, 1,1,16'h0204, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,1,16'h0105, 1,1,16'h0205, 1, 1,1,0,1,1, 2));
        run_tbl("alt");

        // s0 alone streams past the burst cap; release points probed by s1 at beat 12.
        do_reset();
        tbl.push_back(V(1,0,16'h1000, 0,0,16'h0000, 1, 0,0,0,0,0, 0));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(V(1,0,16'h1000 + 16'(k), 0,0,16'h0000, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h100b, 1,1,16'h3100, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h100c, 1,1,16'h3100, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h100d, 1,1,16'h3100, 1, 1,1,0,1,1, 2));
        run_tbl("solo");

        // 6-beat s0 packet split by the cap around one s1 packet.
        do_reset();
        tbl.push_back(V(1,0,16'h2001, 1,1,16'h3001, 1, 0,0,0,0,0, 0));
        tbl.push_back(V(1,0,16'h2001, 1,1,16'h3001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h2002, 1,1,16'h3001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h2003, 1,1,16'h3001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h2004, 1,1,16'h3001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h2005, 1,1,16'h3001, 1, 1,1,0,1,1, 2));
        tbl.push_back(V(1,0,16'h2005, 1,1,16'h3002, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,1,16'h2006, 1,1,16'h3002, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(0,0,16'h0000, 1,1,16'h3002, 1, 1,1,0,1,1, 2));
        tbl.push_back(V(0,0,16'h0000, 0,0,16'h0000, 1, 0,1,0,1,1, 2));
        run_tbl("split");

        // Valid gap and 5-cycle queue stall mid-burst hold grant and count.
        do_reset();
        tbl.push_back(V(1,0,16'h4001, 0,0,16'h0000, 1, 0,0,0,0,0, 0));
        tbl.push_back(V(1,0,16'h4001, 0,0,16'h0000, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(0,0,16'h4002, 1,1,16'h5001, 1, 0,0,1,0,1, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(V(1,0,16'h4002, 1,1,16'h5001, 0, 1,0,0,0,1, 1));
        tbl.push_back(V(1,0,16'h4002, 1,1,16'h5001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h4003, 1,1,16'h5001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h4004, 1,1,16'h5001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,0,16'h4005, 1,1,16'h5001, 1, 1,1,0,1,1, 2));
        run_tbl("stall");

        // MAX_BURST=1: every beat releases, so long packets still alternate.
        do_reset();
        bus1.s0_valid_i = 1; bus1.s0_last_i = 0; bus1.s0_data_i = pay(16'h8001);
        bus1.s1_valid_i = 1; bus1.s1_last_i = 0; bus1.s1_data_i = pay(16'h9001);
        bus1.q_rdy_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("mb1 idle q_valid", bus1.q_valid_o, 1'b0);
            end else begin
                chk($sformatf("mb1 c%0d q_valid", k), bus1.q_valid_o, 1'b1);
                chk($sformatf("mb1 c%0d q_src", k), bus1.q_src_o, logic'((k - 1) % 2));
                chk($sformatf("mb1 c%0d q_data", k), bus1.q_data_o,
                    (k % 2 == 1) ? pay(16'h8001) : pay(16'h9001));
            end
            @(posedge clk);
            #1;
        end
        bus1.s1_valid_i = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mb1 solo%0d q_src", k), bus1.q_src_o, 1'b0);
            chk($sformatf("mb1 solo%0d s0_rdy", k), bus1.s0_rdy_o, 1'b1);
            @(posedge clk);
            #1;
        end

        // Reset pulled mid-burst while s1 holds the grant and rr_ptr points at s1.
        do_reset();
        tbl.push_back(V(1,1,16'h6001, 0,0,16'h0000, 1, 0,0,0,0,0, 0));
        tbl.push_back(V(1,1,16'h6001, 1,0,16'h7001, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(0,0,16'h0000, 1,0,16'h7001, 1, 1,1,0,1,1, 2));
        run_tbl("prerst");
        tbl.push_back(V(0,0,16'h0000, 1,0,16'h7002, 1, 1,1,0,1,1, 2));
        drive(tbl[0]);
        @(negedge clk);
        check_row(tbl[0], "beat2", 0);
        tbl.delete();
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check_all_zero("midrst held");
        reset_n = 1'b1;
        tbl.push_back(V(1,1,16'h6100, 1,1,16'h7100, 1, 0,0,0,0,0, 0));
        tbl.push_back(V(1,1,16'h6101, 1,1,16'h7101, 1, 1,0,1,0,1, 1));
        tbl.push_back(V(1,1,16'h6102, 1,1,16'h7102, 1, 1,1,0,1,1, 2));
        run_tbl("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
